output_drain: RTL and testbench

OUTPUT_DRAIN -- requirements
Module: output_drain

---
 rtl/output_drain_pkg.sv | 19 +
 rtl/output_drain_row_serializer.sv | 117 +++++++++++
 rtl/output_drain.sv | 141 ++++++++++++++
 tb/tb_output_drain.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_drain_pkg.sv
// Shared types and helpers for the output-buffer drain engine.
// Holds the job FSM state encoding and the beats-per-row calculation.
// No logic here; imported by the top and the row serializer.
package output_drain_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Number of stream beats needed to carry one output-buffer row.
  function automatic int beats_per_row(input int lanes, input int beat_lanes);
    return lanes / beat_lanes;
  endfunction

endpackage

// File: rtl/output_drain_row_serializer.sv
// Row register plus beat mux: turns one captured row into LANES/BEAT_LANES beats.
// Latency: first beat valid the cycle after load; one beat per cycle while ready is high.
// Backpressure: valid and data are held while ready is low; with OUTPUT_DRAIN_PREFETCH_EN
// a second row register buffers the next row so the row boundary costs no bubble.
module row_serializer
  import output_drain_pkg::*;
#(
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BEAT_LANES = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic                             load_last,
  input  logic [DATA_WIDTH-1:0]            load_data [LANES],
  input  logic                             ready,
  output logic [BEAT_LANES*DATA_WIDTH-1:0] data,
  output logic                             valid,
  output logic                             last,
  output logic                             row_done
);

  localparam int NB = beats_per_row(LANES, BEAT_LANES);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

  logic [DATA_WIDTH-1:0] cur_row [LANES];
  logic                  cur_last;
  logic [BW-1:0]         beat;
  logic                  fire;
  logic                  finish;
  logic                  free;

`ifdef OUTPUT_DRAIN_PREFETCH_EN
  logic [DATA_WIDTH-1:0] nxt_row [LANES];
  logic                  nxt_vld;
  logic                  nxt_last;
`endif

  assign fire     = valid & ready;
  assign finish   = fire & (beat == LAST_BEAT);
  assign free     = ~valid | finish;
  assign row_done = finish;
  assign last     = valid & cur_last & (beat == LAST_BEAT);

  // Row register, beat counter and valid; a new row enters only when the current one is gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_row  <= '{default: '0};
      cur_last <= 1'b0;
      beat     <= '0;
      valid    <= 1'b0;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
      nxt_row  <= '{default: '0};
      nxt_vld  <= 1'b0;
      nxt_last <= 1'b0;
`endif
    end else begin
      if (fire && !finish) beat <= beat + 1'b1;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
      if (free) begin
        if (nxt_vld) begin
          // Buffered row is older than anything arriving now, so it goes out first.
          cur_row  <= nxt_row;
          cur_last <= nxt_last;
          valid    <= 1'b1;
          beat     <= '0;
          if (load) begin
            nxt_row  <= load_data;
            nxt_last <= load_last;
          end else begin
            nxt_vld <= 1'b0;
          end
        end else if (load) begin
          cur_row  <= load_data;
          cur_last <= load_last;
          valid    <= 1'b1;
          beat     <= '0;
        end else begin
          valid <= 1'b0;
          beat  <= '0;
        end
      end else if (load) begin
        nxt_row  <= load_data;
        nxt_last <= load_last;
        nxt_vld  <= 1'b1;
      end
`else
      if (free) begin
        if (load) begin
          cur_row  <= load_data;
          cur_last <= load_last;
          valid    <= 1'b1;
          beat     <= '0;
        end else begin
          valid <= 1'b0;
          beat  <= '0;
        end
      end
`endif
    end
  end

  // Beat mux: beat n carries lanes n*B..n*B+B-1, lowest lane in the low bits.
  always_comb begin
    data = '0;
    for (int n = 0; n < NB; n++) begin
      if (beat == BW'(n)) begin
        for (int i = 0; i < BEAT_LANES; i++) begin
          data[i*DATA_WIDTH +: DATA_WIDTH] = cur_row[n*BEAT_LANES + i];
        end
      end
    end
  end

endmodule

// File: rtl/output_drain.sv
// Drains row_count output-buffer rows starting at base_addr into a beat stream.
// Latency: 2 cycles to first beat, then W/B beats per row (+2 per row without OUTPUT_DRAIN_PREFETCH_EN).
// Backpressure: m_ready low stalls the stream with data held; reads are issued only when a row slot is free.
module output_drain #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int ADDR_WIDTH           = 10,
  parameter int BEAT_LANES           = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH:0]              row_count,
  output logic [ADDR_WIDTH-1:0]            ob_rd_addr,
  output logic                             ob_rd_en,
  input  logic [DATA_WIDTH-1:0]            ob_rd_data [SYSTOLIC_ARRAY_WIDTH],
  output logic [BEAT_LANES*DATA_WIDTH-1:0] m_data,
  output logic                             m_valid,
  output logic                             m_last,
  input  logic                             m_ready,
  output logic                             busy,
  output logic                             done
);
  import output_drain_pkg::*;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_WIDTH:0] rd_left;    // rows not yet read from the buffer
  logic [ADDR_WIDTH:0] rows_left;  // rows not yet fully sent
  logic              rd_last;
  logic              cap_vld;
  logic              cap_last;
  logic              row_done;

  // Job FSM: accepts start in IDLE, issues row reads and tracks rows sent until DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ob_rd_en   <= 1'b0;
      ob_rd_addr <= '0;
      rd_left    <= '0;
      rows_left  <= '0;
      rd_last    <= 1'b0;
      cap_vld    <= 1'b0;
      cap_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ob_rd_en <= 1'b0;
      done     <= 1'b0;
      // Read data returns one cycle after the enable; tag it with its final-row flag.
      cap_vld  <= ob_rd_en;
      cap_last <= rd_last;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            rows_left <= row_count;
            if (row_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= READ;
              ob_rd_en   <= 1'b1;
              ob_rd_addr <= base_addr;
              rd_last    <= (row_count == ONE);
              rd_left    <= row_count - ONE;
            end
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state <= SEND;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
          // Fetch the next row during the first beat of this one.
          if (rd_left != '0) begin
            ob_rd_en   <= 1'b1;
            ob_rd_addr <= ob_rd_addr + 1'b1;
            rd_last    <= (rd_left == ONE);
            rd_left    <= rd_left - ONE;
          end
`endif
        end
        SEND: begin
          if (row_done) begin
            rows_left <= rows_left - ONE;
            if (rows_left == ONE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
`ifdef OUTPUT_DRAIN_PREFETCH_EN
              // Next row is already buffered; keep one read ahead of the stream.
              if (rd_left != '0) begin
                ob_rd_en   <= 1'b1;
                ob_rd_addr <= ob_rd_addr + 1'b1;
                rd_last    <= (rd_left == ONE);
                rd_left    <= rd_left - ONE;
              end
`else
              state      <= READ;
              ob_rd_en   <= 1'b1;
              ob_rd_addr <= ob_rd_addr + 1'b1;
              rd_last    <= (rd_left == ONE);
              rd_left    <= rd_left - ONE;
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  row_serializer #(
    .LANES      (SYSTOLIC_ARRAY_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BEAT_LANES (BEAT_LANES)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cap_vld),
    .load_last (cap_last),
    .load_data (ob_rd_data),
    .ready     (m_ready),
    .data      (m_data),
    .valid     (m_valid),
    .last      (m_last),
    .row_done  (row_done)
  );

endmodule

// File: tb/tb_output_drain.sv
// Scoreboard bench for output_drain: a memory model answers reads, a spec-level model
// queues expected read addresses and beats per job, and a monitor pops them as the DUT emits.
// Build with OUTPUT_DRAIN_PREFETCH_EN defined to expect the zero-bubble job timing.
module tb_output_drain;

  localparam int W  = 16;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int B  = 4;
  localparam int NB = W / B;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       row_count;
  logic [AW-1:0]     ob_rd_addr;
  logic              ob_rd_en;
  logic [DW-1:0]     ob_rd_data [W];
  logic [B*DW-1:0]   m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready;
  logic              busy;
  logic              done;

  typedef struct {
    logic [B*DW-1:0] data;
    logic            last;
  } beat_t;

  logic [DW-1:0] mem [DEPTH][W];
  beat_t         exp_q [$];
  int            addr_q [$];
  int            total = 0;
  int            bad = 0;
  int            beats_seen = 0;
  int            reads_seen = 0;
  int            dones = 0;
  int            ready_mode = 0;

  always #5 clk = ~clk;

  output_drain #(
    .SYSTOLIC_ARRAY_WIDTH (W),
    .DATA_WIDTH           (DW),
    .ADDR_WIDTH           (AW),
    .BEAT_LANES           (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_count  (row_count),
    .ob_rd_addr (ob_rd_addr),
    .ob_rd_en   (ob_rd_en),
    .ob_rd_data (ob_rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .busy       (busy),
    .done       (done)
  );

  // Output-buffer model: data one cycle after the enable, garbage otherwise.
  always @(posedge clk) begin
    for (int i = 0; i < W; i++) ob_rd_data[i] <= ob_rd_en ? mem[ob_rd_addr][i] : DW'($urandom);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rows base..base+rc-1 modulo depth, each split into NB beats.
  task automatic expect_job(input int base, input int rc);
    for (int r = 0; r < rc; r++) begin
      int a;
      a = (base + r) % DEPTH;
      addr_q.push_back(a);
      for (int n = 0; n < NB; n++) begin
        beat_t e;
        for (int i = 0; i < B; i++) e.data[i*DW +: DW] = mem[a][n*B + i];
        e.last = (r == rc - 1) && (n == NB - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: samples just after m_ready has been set for the coming edge.
  initial begin
    bit              prev_stall;
    logic [B*DW-1:0] prev_data;
    beat_t           e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, prev_data);
        end
        if (m_valid && m_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", m_data, e.data);
            check("beat_last", m_last, e.last);
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (ob_rd_en) begin
          reads_seen++;
          if (addr_q.size() == 0) check("unexpected_read", 1, 0);
          else check("rd_addr", ob_rd_addr, addr_q.pop_front());
        end
        if (done) dones++;
      end
    end
  end

  // Ready driver: 0 = always ready, 1 = random, 2 = three-cycle stall after two beats.
  initial begin
    int stalled;
    stalled = 0;
    m_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (beats_seen == 0) stalled = 0;
      case (ready_mode)
        1: m_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (beats_seen == 2 && stalled < 3) begin
            m_ready = 1'b0;
            stalled++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  task automatic run_job(input int base, input int rc, input int mode, input bit mid);
    int cyc;
    bit got;
    int exp_lat;
`ifdef OUTPUT_DRAIN_PREFETCH_EN
    exp_lat = (rc == 0) ? 1 : 3 + rc * NB;
`else
    exp_lat = (rc == 0) ? 1 : rc * (NB + 2) + 1;
`endif
    ready_mode = mode;
    expect_job(base, rc);
    beats_seen = 0;
    reads_seen = 0;
    dones = 0;
    @(negedge clk);
    base_addr = AW'(base);
    row_count = (AW+1)'(rc);
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 4000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (mid && cyc == 3) begin
        start = 1'b1;
        base_addr = AW'($urandom);
        row_count = (AW+1)'($urandom_range(1, 7));
      end
      if (mid && cyc == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", got, 1);
    if (got && mode == 0) check("job_latency", cyc, exp_lat);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("done_count", dones, 1);
    check("beat_count", beats_seen, rc * NB);
    check("read_count", reads_seen, rc);
    check("beats_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
  endtask

  task automatic reset_mid_job();
    int n;
    int beats0;
    ready_mode = 0;
    expect_job(int'($urandom_range(0, DEPTH - 1)), 4);
    beats_seen = 0;
    reads_seen = 0;
    @(negedge clk);
    base_addr = AW'(addr_q[0]);
    row_count = (AW+1)'(4);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (beats_seen < NB + 1 && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("reached_row1", beats_seen >= NB + 1, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ob_rd_en", ob_rd_en, 0);
    check("rst_ob_rd_addr", ob_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    exp_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    beats0 = beats_seen;
    repeat (10) @(negedge clk);
    check("no_beats_after_reset", beats_seen, beats0);
    check("idle_after_reset", busy, 0);
    check("valid_after_reset", m_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    for (int a = 0; a < DEPTH; a++)
      for (int i = 0; i < W; i++) mem[a][i] = $urandom;
    #12;
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    check("reset_ob_rd_en", ob_rd_en, 0);
    check("reset_ob_rd_addr", ob_rd_addr, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_job(5, 2, 0, 1'b0);
    run_job(7, 0, 0, 1'b0);
    run_job(100, 2, 2, 1'b0);
    run_job(1023, 2, 0, 1'b0);
    run_job(40, 3, 0, 1'b0);
    reset_mid_job();
    run_job(200, 3, 0, 1'b1);
    for (int j = 0; j < 16; j++) begin
      run_job(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
